// File: rtl/instr_cache_pkg.sv
// instr_cache_pkg: shared state codes and address-split helpers for the instruction cache.
// Contents: refill FSM state codes, field width/position functions, addr_field extractor.
package instr_cache_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t REFILL = 2'd1;
    localparam state_t COMMIT = 2'd2;

    function automatic int word_bits(int words);
        return $clog2(words);
    endfunction

    function automatic int index_bits(int sets);
        return $clog2(sets);
    endfunction

    function automatic int index_lsb(int words);
        return 2 + $clog2(words);
    endfunction

    function automatic int tag_lsb(int sets, int words);
        return 2 + $clog2(words) + $clog2(sets);
    endfunction

    function automatic int tag_bits(int width, int sets, int words);
        return width - tag_lsb(sets, words);
    endfunction

    // Extracts addr[lsb +: bits]; callers truncate the result to the field width.
    function automatic logic [63:0] addr_field(logic [63:0] addr, int lsb, int bits);
        return (addr >> lsb) & ((64'd1 << bits) - 64'd1);
    endfunction

endpackage

// File: rtl/instr_cache_if.sv
// instr_cache_if: word read bus between the instruction cache and the memory arbiter.
// Signals: req/addr driven by the cache (master), ack/rdata returned by memory (slave).
interface instr_cache_if #(parameter int WIDTH = 32);

    logic             req;
    logic [WIDTH-1:0] addr;
    logic             ack;
    logic [WIDTH-1:0] rdata;

    modport master(output req, addr, input ack, rdata);
    modport slave(input req, addr, output ack, rdata);

endinterface

// File: rtl/icache_refill_fsm.sv
// icache_refill_fsm: line refill sequencer for the instruction cache.
// Ports: clk/rst (async active-low); start = miss allowed to refill, base = line base address,
// invalidate = fence.i pulse; outputs state, pending_inv, word count, word_wr/commit strobes,
// mem_req/mem_addr to memory, mem_ack from memory.
module icache_refill_fsm
    import instr_cache_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int WORDS_PER_LINE = 4,
    localparam int WB            = word_bits(WORDS_PER_LINE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic             invalidate,
    input  logic             mem_ack,
    output state_t           state,
    output logic             pending_inv,
    output logic [WB-1:0]    count,
    output logic             word_wr,
    output logic             commit,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr
);

    // An ack only counts while a request is actually outstanding.
    assign word_wr = state == REFILL && mem_req && mem_ack;
    assign commit  = state == COMMIT;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pending_inv <= 1'b0;
            count       <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
        end else begin
            // Invalidates seen mid-refill are held until the first IDLE cycle, which then consumes them.
            pending_inv <= state == IDLE ? 1'b0 : pending_inv | invalidate;
            if (state == IDLE && start) begin
                state    <= REFILL;
                count    <= '0;
                mem_req  <= 1'b1;
                mem_addr <= base;
            end else if (word_wr) begin
                count <= count + WB'(1);
                if (&count) begin
                    mem_req <= 1'b0;
                    state   <= COMMIT;
                end else begin
                    mem_addr <= mem_addr + WIDTH'(4);
                end
            end else if (commit) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: rtl/instr_cache.sv
// instr_cache: direct-mapped instruction cache between fetch and the memory arbiter.
// Ports: clk/rst (async active-low); fetch_req/PCF from fetch, invalidate (fence.i);
// InstrF/InstrValidF/StallF back to fetch/decode; mem = word refill bus (master side).
module instr_cache
    import instr_cache_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int SETS           = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_req,
    input  logic [WIDTH-1:0]   PCF,
    input  logic               invalidate,
    output logic [WIDTH-1:0]   InstrF,
    output logic               InstrValidF,
    output logic               StallF,
    instr_cache_if.master      mem
);

    localparam int IB = index_bits(SETS);
    localparam int WB = word_bits(WORDS_PER_LINE);
    localparam int TB = tag_bits(WIDTH, SETS, WORDS_PER_LINE);
    localparam int IL = index_lsb(WORDS_PER_LINE);
    localparam int TL = tag_lsb(SETS, WORDS_PER_LINE);

    logic [SETS-1:0]  valid;
    logic [TB-1:0]    tags [SETS];
    logic [WIDTH-1:0] data [SETS][WORDS_PER_LINE];

    state_t        state;
    logic          pending_inv, word_wr, commit, inv_now, hit, start;
    logic [WB-1:0] count;
    logic [IB-1:0] idx, rix;
    logic [WB-1:0] wrd;
    logic [TB-1:0] tag, rtag;

    assign idx  = IB'(addr_field(64'(PCF), IL, IB));
    assign wrd  = WB'(addr_field(64'(PCF), 2, WB));
    assign tag  = TB'(addr_field(64'(PCF), TL, TB));
    // Refill target comes from the latched refill address, never from the live PCF.
    assign rix  = IB'(addr_field(64'(mem.addr), IL, IB));
    assign rtag = TB'(addr_field(64'(mem.addr), TL, TB));

    // A live or deferred invalidate in IDLE forces a miss and blocks a refill this cycle.
    assign inv_now     = state == IDLE && (invalidate || pending_inv);
    assign hit         = fetch_req && state == IDLE && !inv_now && valid[idx] && tags[idx] == tag;
    assign start       = fetch_req && !hit && !inv_now;
    assign StallF      = fetch_req && !hit;
    assign InstrValidF = hit;
    assign InstrF      = hit ? data[idx][wrd] : '0;

    icache_refill_fsm #(.WIDTH(WIDTH), .WORDS_PER_LINE(WORDS_PER_LINE)) u_fsm (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base       ({PCF[WIDTH-1:IL], {IL{1'b0}}}),
        .invalidate (invalidate),
        .mem_ack    (mem.ack),
        .state      (state),
        .pending_inv(pending_inv),
        .count      (count),
        .word_wr    (word_wr),
        .commit     (commit),
        .mem_req    (mem.req),
        .mem_addr   (mem.addr)
    );

    // The victim line is invalidated as the refill starts so a partial line never hits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) valid <= '0;
        else if (inv_now) valid <= '0;
        else if (state == IDLE && start) valid[idx] <= 1'b0;
        else if (commit) valid[rix] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (word_wr) data[rix][count] <= mem.rdata;
        if (commit) tags[rix] <= rtag;
    end

endmodule

// File: doc/instr_cache.md
Name: instr_cache

Overview:
- Direct-mapped instruction cache; the responder the fetch stage talks to.
- Takes PCF from fetch and returns InstrF, which the pipeline feeds into the decode register's InstrDi.
- On a miss it asserts StallF and refills the line from main memory over a req/ack word interface, using a refill state machine.
- Sits between fetch and the unified memory arbiter.

Parameters:
- WIDTH, 32, address and instruction width.
- SETS, 16, number of lines; power of two, ≥2.
- WORDS_PER_LINE, 4, 32-bit words per line; power of two, ≥2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- fetch_req  in  1  fetch wants an instruction this cycle.
- PCF  in  WIDTH  fetch address; bits [1:0] ignored.
- invalidate  in  1  fence.i: invalidate all lines (single-cycle pulse).
- InstrF  out  WIDTH  instruction word for PCF.
- InstrValidF  out  1  InstrF valid (hit).
- StallF  out  1  stall fetch and decode enables.
- mem_req  out  1  word read request to memory.
- mem_addr  out  WIDTH  word-aligned refill address.
- mem_ack  in  1  memory returns mem_rdata this cycle.
- mem_rdata  in  WIDTH  refill data.

Behaviour:
- Address split (defaults):
  - byte offset [1:0]
  - word offset [log2(WORDS_PER_LINE)+1:2] = [3:2]
  - index next log2(SETS) bits = [7:4]
  - tag the rest = [31:8]
- Storage: per line, a valid bit, a tag and WORDS_PER_LINE data words, all in flops.
- Reset (rst low, async):
  - all valid bits = 0, state = IDLE, pending_inv = 0.
  - mem_req = 0, mem_addr = 0, refill counter = 0.
  - InstrF = 0, InstrValidF = 0.
- hit = fetch_req & valid[index] & (tag[index] == PCF tag) & state==IDLE.
- Hit:
  - combinational, zero latency: InstrF = data[index][word], InstrValidF = 1, StallF = 0.
  - When InstrValidF = 0, InstrF = 0.
- StallF = fetch_req & ~hit, combinational. StallF is high in every non-IDLE state while fetch_req is high.
- fetch_req low: no lookup, StallF = 0, InstrValidF = 0, no refill started.
- States: IDLE, REFILL, COMMIT.
  - IDLE → REFILL on a miss (fetch_req & ~hit) when no invalidate is in progress.
    - Latch line base = {PCF tag, index, zeros}.
    - Counter = 0.
    - Next cycle: mem_req = 1, mem_addr = base.
  - REFILL:
    - mem_req held high and mem_addr stable until mem_ack.
    - Exactly one request outstanding at a time.
    - On mem_ack: write mem_rdata to data[index][counter] and increment the counter.
    - If the counter was WORDS_PER_LINE-1: drop mem_req and go to COMMIT.
    - Otherwise: mem_addr += 4 and mem_req stays high.
    - mem_ack while mem_req is low is ignored.
  - COMMIT (1 cycle): set valid[index] = 1, write tag, go to IDLE. Next cycle the lookup hits.
- Miss penalty with memory ack latency L cycles per word: 1 + WORDS_PER_LINE·L + 1 cycles from miss to hit. No critical-word forwarding.
- The refill address comes only from the latched base. A PCF change during a refill does not alter the refill; after COMMIT the lookup uses the current PCF.
- The old line's valid bit is cleared on entry to REFILL, so a partial line is never hit.
- invalidate:
  - In IDLE: clear all valid bits at the next edge. Lookup in the same cycle is forced to miss (StallF = 1 if fetch_req). No refill starts that cycle.
  - In REFILL or COMMIT: set pending_inv. Complete the refill, then in the IDLE cycle after COMMIT clear all valid bits (the refilled line included) and clear pending_inv.
  - An invalidate coincident with the COMMIT→IDLE transition is treated as pending.
- Reset mid-refill: immediate abort, mem_req = 0 asynchronously, the partial line is never valid. The memory side must drop any in-flight ack.
- Index wrap: the counter wraps within the line only. mem_addr never crosses the line boundary.

Decomposition:
- Package instr_cache_pkg holds:
  - state enum (IDLE/REFILL/COMMIT);
  - functions returning the index, tag and word-offset widths and bit positions from SETS/WORDS_PER_LINE;
  - the address-split helper.
- Sub-module icache_refill_fsm: state register, counter, mem_req/mem_addr generation, pending_inv. Tag/valid/data arrays and the hit logic stay in the top.

Test Plan:
- After reset, fetch_req=1, PCF=0x0000_0100, memory acks 2 cycles after each req, data = address:
  - mem_addr sequence 0x100, 0x104, 0x108, 0x10C with one req each.
  - StallF high throughout.
  - COMMIT, then InstrF = 0x100 with InstrValidF = 1.
- Same line hit: PCF = 0x0000_0108 → same-cycle InstrF = 0x108, StallF = 0, no mem_req.
- Conflict: PCF = 0x0000_1100 (same index 0) → refill 0x1100–0x110C, then PCF = 0x100 misses again and refetches.
- invalidate pulsed at the 2nd ack of a refill → refill completes, all lines invalid the cycle after COMMIT, that PCF misses again.
- rst low mid-refill after the 1st ack → mem_req = 0 immediately. After release, PCF = 0x100 misses and restarts at 0x100.
- fetch_req = 0 with a cold cache → StallF = 0, mem_req stays 0 for 10 cycles. invalidate in IDLE forces a miss in the same cycle.
